// File: rtl/cv_input_pkg.sv
// Shared types and constants for the keyboard matrix slice (cv_key_matrix, cv_key_cell).
package cv_input_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 8;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef struct packed {
        logic [1:0] row;
        logic [2:0] col;
    } key_idx_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } kbd_state_t;

endpackage

// File: rtl/cv_key_cell.sv
// One key of the matrix: press flag plus optional hold-stretch age/pending state.
// Hold stretching is present only when CV_KEY_STRETCH_EN is defined.
module cv_key_cell #(
    parameter int unsigned HOLD_FRAMES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick,
    input  logic press_ev,
    input  logic release_ev,
    input  logic clear,
    output logic pressed
);

`ifdef CV_KEY_STRETCH_EN
    localparam logic [1:0] HOLD = 2'(HOLD_FRAMES);

    logic       press_q, press_d;
    logic [1:0] age_q, age_d;
    logic       pend_q, pend_d;
    logic [1:0] age_inc;

    always_comb begin
        press_d = press_q;
        age_d   = age_q;
        pend_d  = pend_q;
        age_inc = (age_q == 2'd3) ? age_q : age_q + 2'd1;
        if (clear) begin
            press_d = 1'b0;
            age_d   = '0;
            pend_d  = 1'b0;
        end else if (press_ev) begin
            press_d = 1'b1;
            age_d   = '0;
            pend_d  = 1'b0;
        end else if (release_ev) begin
            if (press_q) begin
                if (age_q >= HOLD) begin
                    press_d = 1'b0;
                    age_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end
        end else if (frame_tick && press_q) begin
            // A pending release completes on the tick that brings the age up to the hold time.
            if (pend_q && (age_inc >= HOLD)) begin
                press_d = 1'b0;
                age_d   = '0;
                pend_d  = 1'b0;
            end else begin
                age_d = age_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q <= 1'b0;
            age_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            press_q <= press_d;
            age_q   <= age_d;
            pend_q  <= pend_d;
        end
    end
`else
    logic press_q, press_d;
    logic unused_cfg;

    assign unused_cfg = frame_tick ^ (HOLD_FRAMES > 3);

    always_comb begin
        press_d = press_q;
        if (clear || release_ev) begin
            press_d = 1'b0;
        end else if (press_ev) begin
            press_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q <= 1'b0;
        end else begin
            press_q <= press_d;
        end
    end
`endif

    assign pressed = press_q;

endmodule

// File: rtl/cv_key_matrix.sv
// 4x8 keyboard matrix emulation: host key events in, active-low PIA column lines out.
// Define CV_KEY_STRETCH_EN to enable minimum-hold stretching of key releases.
module cv_key_matrix
    import cv_input_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [4:0] ev_code,
    input  logic       ev_press,
    input  logic       ev_clear,
    input  logic [3:0] row_sel,
    output logic [7:0] col_out
);

    kbd_state_t          state_q, state_d;
    logic [1:0]          row_cnt_q, row_cnt_d;
    logic                ev_ready_q, ev_ready_d;
    logic [7:0]          col_out_q, col_out_d;

    key_idx_t            key;
    logic                accept;
    logic                key_ev;
    logic [NUM_ROWS-1:0] clr_row;
    logic [NUM_KEYS-1:0] key_pressed;

    assign key    = key_idx_t'(ev_code);
    assign accept = ev_valid & ev_ready_q;
    assign key_ev = accept & ~ev_clear;

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        ev_ready_d = ev_ready_q;
        case (state_q)
            ST_IDLE: begin
                ev_ready_d = 1'b1;
                if (accept && ev_clear) begin
                    state_d    = ST_CLEAR;
                    row_cnt_d  = '0;
                    ev_ready_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                ev_ready_d = 1'b0;
                row_cnt_d  = row_cnt_q + 2'd1;
                if (row_cnt_q == 2'd3) begin
                    state_d    = ST_IDLE;
                    ev_ready_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ev_ready_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        clr_row = '0;
        if (state_q == ST_CLEAR) begin
            clr_row[row_cnt_q] = 1'b1;
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            logic hit;
            assign hit = key_ev && (key.row == 2'(r)) && (key.col == 3'(c));

            cv_key_cell #(
                .HOLD_FRAMES(HOLD_FRAMES)
            ) u_cell (
                .clk        (clk),
                .reset_n    (reset_n),
                .frame_tick (frame_tick),
                .press_ev   (hit & ev_press),
                .release_ev (hit & ~ev_press),
                .clear      (clr_row[r]),
                .pressed    (key_pressed[r*NUM_COLS+c])
            );
        end
    end

    // Selected rows are ORed together; no row selected leaves every column released.
    always_comb begin
        logic [NUM_COLS-1:0] acc;
        acc = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (!row_sel[r]) begin
                acc = acc | key_pressed[r*NUM_COLS +: NUM_COLS];
            end
        end
        col_out_d = ~acc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            row_cnt_q  <= '0;
            ev_ready_q <= 1'b0;
            col_out_q  <= '1;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            ev_ready_q <= ev_ready_d;
            col_out_q  <= col_out_d;
        end
    end

    assign ev_ready = ev_ready_q;
    assign col_out  = col_out_q;

endmodule
